// File: rtl/cpu_trace_dumper.sv
// Snapshots PC and cycle/stall/flush counters on trigger, then streams a header, the register file and low data memory as one frame.
// Latency: word 0 is valid the cycle after the trigger edge; header words 1/cycle; register and memory words 2 cycles each (fetch + send).
// Backpressure: a valid word holds data/last until tx_ready_i; every ready-low cycle stretches the frame by one cycle.
module cpu_trace_dumper #(
    parameter int NUM_REGS      = 32,
    parameter int NUM_MEM_WORDS = 8,
    parameter int CNT_W         = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        trigger_i,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [4:0]  reg_addr_o,
    input  logic [31:0] reg_data_i,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_data_i,
    output logic [31:0] tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        tx_last_o,
    output logic        busy_o,
    output logic        overflow_o
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        REG_FETCH,
        REG_SEND,
        MEM_FETCH,
        MEM_SEND
    } state_t;

    localparam logic [4:0]       REG_LAST = 5'(NUM_REGS - 1);
    localparam logic [31:0]      MEM_LAST = 32'((NUM_MEM_WORDS - 1) * 4);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [2:0]       HDR_LAST = 3'd4;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;
    logic [CNT_W-1:0] snap_cycle, snap_stall, snap_flush;
    logic [31:0]      snap_pc;
    logic [15:0]      seq;
    logic [2:0]       hdr_idx;
    logic             tx_acc;
    logic             reg_last;
    logic             mem_last;

    assign tx_acc   = tx_valid_o & tx_ready_i;
    assign reg_last = (reg_addr_o == REG_LAST);
    assign mem_last = (mem_addr_o == MEM_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        tx_valid_o = 1'b0;
        tx_last_o  = 1'b0;
        busy_o     = 1'b1;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (trigger_i) begin
                    state_nxt = HDR;
                end
            end
            HDR: begin
                tx_valid_o = 1'b1;
                if (tx_acc && hdr_idx == HDR_LAST) begin
                    state_nxt = REG_FETCH;
                end
            end
            REG_FETCH: begin
                state_nxt = REG_SEND;
            end
            REG_SEND: begin
                tx_valid_o = 1'b1;
                if (tx_acc) begin
                    state_nxt = reg_last ? MEM_FETCH : REG_FETCH;
                end
            end
            MEM_FETCH: begin
                state_nxt = MEM_SEND;
            end
            MEM_SEND: begin
                tx_valid_o = 1'b1;
                tx_last_o  = mem_last;
                if (tx_acc) begin
                    state_nxt = mem_last ? IDLE : MEM_FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_o    = 1'b0;
            end
        endcase
    end

    // Free-running performance counters; they keep counting through a dump.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (start_i) begin
            cycle_cnt <= cycle_cnt + CNT_ONE;
            if (stall_i) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush_i) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
        end else if (trigger_i && state != IDLE) begin
            overflow_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            snap_cycle <= '0;
            snap_stall <= '0;
            snap_flush <= '0;
            snap_pc    <= '0;
            seq        <= '0;
            hdr_idx    <= '0;
            tx_data_o  <= '0;
            reg_addr_o <= '0;
            mem_addr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger_i) begin
                        snap_cycle <= cycle_cnt;
                        snap_stall <= stall_cnt;
                        snap_flush <= flush_cnt;
                        snap_pc    <= pc_i;
                        hdr_idx    <= '0;
                        tx_data_o  <= 32'hD0D0_0000 | {16'h0000, seq};
                    end
                end
                HDR: begin
                    if (tx_acc) begin
                        hdr_idx <= hdr_idx + 3'd1;
                        case (hdr_idx)
                            3'd0:    tx_data_o <= 32'(snap_cycle);
                            3'd1:    tx_data_o <= snap_pc;
                            3'd2:    tx_data_o <= 32'(snap_stall);
                            3'd3:    tx_data_o <= 32'(snap_flush);
                            default: reg_addr_o <= '0;
                        endcase
                    end
                end
                REG_FETCH: begin
                    tx_data_o <= reg_data_i;
                end
                REG_SEND: begin
                    if (tx_acc) begin
                        if (reg_last) begin
                            mem_addr_o <= '0;
                        end else begin
                            reg_addr_o <= reg_addr_o + 5'd1;
                        end
                    end
                end
                MEM_FETCH: begin
                    tx_data_o <= mem_data_i;
                end
                MEM_SEND: begin
                    if (tx_acc) begin
                        if (mem_last) begin
                            seq <= seq + 16'd1;
                        end else begin
                            mem_addr_o <= mem_addr_o + 32'd4;
                        end
                    end
                end
                default: begin
                    hdr_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_trace_dumper.sv
// Randomized bench for cpu_trace_dumper: a frame model built from counter/seq/register/memory arrays
// is compared word by word against the stream, including hold stability, overflow and mid-frame reset.
module tb_cpu_trace_dumper;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, trigger_i, stall_i, flush_i, tx_ready_i;
    logic [31:0] pc_i;
    logic [4:0]  reg_addr_o;
    logic [31:0] reg_data_i, mem_addr_o, mem_data_i, tx_data_o;
    logic        tx_valid_o, tx_last_o, busy_o, overflow_o;

    logic [31:0] regs [32];
    logic [31:0] memw [8];
    logic [31:0] got  [45];
    logic [31:0] m_cycle, m_stall, m_flush;
    logic [15:0] m_seq;
    int          checks = 0;
    int          failures = 0;
    int          acc_cyc;

    always #5 clk_i = ~clk_i;

    assign reg_data_i = regs[reg_addr_o];
    assign mem_data_i = (mem_addr_o < 32'd32) ? memw[mem_addr_o[4:2]] : 32'hBAD0_0000;

    cpu_trace_dumper dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .trigger_i  (trigger_i),
        .pc_i       (pc_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .reg_addr_o (reg_addr_o),
        .reg_data_i (reg_data_i),
        .mem_addr_o (mem_addr_o),
        .mem_data_i (mem_data_i),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .tx_last_o  (tx_last_o),
        .busy_o     (busy_o),
        .overflow_o (overflow_o)
    );

    // Reference counters: one count per edge with start high.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_cycle <= 0;
            m_stall <= 0;
            m_flush <= 0;
        end else if (start_i) begin
            m_cycle <= m_cycle + 1;
            if (stall_i) m_stall <= m_stall + 1;
            if (flush_i) m_flush <= m_flush + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        m_seq = 0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Runs one frame; trig_at injects a second trigger at that cycle, rst_at resets when that word is shown.
    task automatic run_frame(input int ready_pct, input bit rand_ctl, input int trig_at, input int rst_at);
        logic [31:0] exp_w [45];
        logic [31:0] prev_d;
        logic        prev_l;
        bit          prev_hold;
        bit          rdy;
        int          cyc;
        int          widx;
        @(negedge clk_i);
        chk("idle_busy", 32'(busy_o), 32'd0);
        exp_w[0] = 32'hD0D0_0000 | {16'h0000, m_seq};
        exp_w[1] = m_cycle;
        exp_w[2] = pc_i;
        exp_w[3] = m_stall;
        exp_w[4] = m_flush;
        for (int i = 0; i < 32; i++) exp_w[5 + i] = regs[i];
        for (int j = 0; j < 8; j++) exp_w[37 + j] = memw[j];
        trigger_i = 1'b1;
        @(negedge clk_i);
        cyc = 1;
        widx = 0;
        prev_hold = 0;
        prev_d = 0;
        prev_l = 0;
        while (widx < 45 && cyc < 3000) begin
            trigger_i = (cyc == trig_at);
            if (rand_ctl) begin
                start_i = 1'($urandom_range(1));
                stall_i = 1'($urandom_range(1));
                flush_i = 1'($urandom_range(1));
                pc_i    = $urandom;
            end
            if (rst_at == widx && tx_valid_o) begin
                rst_i = 1'b1;
                #1;
                chk("rst_valid", 32'(tx_valid_o), 32'd0);
                chk("rst_busy", 32'(busy_o), 32'd0);
                chk("rst_data", tx_data_o, 32'd0);
                chk("rst_last", 32'(tx_last_o), 32'd0);
                chk("rst_regaddr", 32'(reg_addr_o), 32'd0);
                trigger_i = 1'b0;
                start_i = 1'b0;
                stall_i = 1'b0;
                flush_i = 1'b0;
                tx_ready_i = 1'b0;
                m_seq = 0;
                @(posedge clk_i);
                @(negedge clk_i);
                rst_i = 1'b0;
                return;
            end
            chk("busy", 32'(busy_o), 32'd1);
            if (prev_hold) begin
                chk("hold_valid", 32'(tx_valid_o), 32'd1);
                chk("hold_data", tx_data_o, prev_d);
                chk("hold_last", 32'(tx_last_o), 32'(prev_l));
            end
            if (tx_valid_o) begin
                chk("word", tx_data_o, exp_w[widx]);
                chk("last", 32'(tx_last_o), 32'(widx == 44));
            end
            rdy = ($urandom_range(99) < ready_pct);
            tx_ready_i = rdy;
            if (tx_valid_o && rdy) begin
                got[widx] = tx_data_o;
                widx++;
                if (widx == 45) acc_cyc = cyc;
                prev_hold = 0;
            end else begin
                prev_hold = tx_valid_o;
                prev_d = tx_data_o;
                prev_l = tx_last_o;
            end
            @(negedge clk_i);
            cyc++;
        end
        trigger_i = 1'b0;
        tx_ready_i = 1'b0;
        start_i = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        if (widx < 45) chk("timeout_words", 32'(widx), 32'd45);
        else chk("busy_end", 32'(busy_o), 32'd0);
        m_seq = m_seq + 16'd1;
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        trigger_i = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        tx_ready_i = 1'b0;
        pc_i = 32'h0;
        m_seq = 0;
        acc_cyc = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i + 100);
        for (int j = 0; j < 8; j++) memw[j] = $urandom;
        memw[0] = 32'd5;
        #1;
        chk("reset_valid", 32'(tx_valid_o), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_ovf", 32'(overflow_o), 32'd0);
        chk("reset_data", tx_data_o, 32'd0);
        chk("reset_last", 32'(tx_last_o), 32'd0);
        chk("reset_memaddr", mem_addr_o, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Counting: 10 running edges, 2 stalls, 1 flush.
        for (int k = 0; k < 10; k++) begin
            start_i = 1'b1;
            stall_i = (k == 2 || k == 7);
            flush_i = (k == 5);
            @(negedge clk_i);
        end
        start_i = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        pc_i = 32'h24;
        run_frame(100, 0, 0, -1);
        chk("cnt_header", got[0], 32'hD0D0_0000);
        chk("cnt_cycle", got[1], 32'd10);
        chk("cnt_stall", got[3], 32'd2);
        chk("cnt_flush", got[4], 32'd1);

        // Full frame at full rate.
        run_frame(100, 0, 0, -1);
        chk("full_accept_cycle", 32'(acc_cyc), 32'd85);
        chk("full_pc", got[2], 32'h24);
        chk("full_reg0", got[5], 32'd100);
        chk("full_mem0", got[37], 32'd5);
        chk("full_header", got[0], 32'hD0D0_0001);

        // Backpressure with random data and live counters.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            for (int j = 0; j < 8; j++) memw[j] = $urandom;
            pc_i = $urandom;
            run_frame(50, 1, 0, -1);
        end

        // Overflow: dropped trigger mid-frame.
        do_reset();
        chk("ovf_clear", 32'(overflow_o), 32'd0);
        run_frame(100, 0, 10, -1);
        chk("ovf_set", 32'(overflow_o), 32'd1);
        repeat (5) @(negedge clk_i);
        chk("ovf_sticky", 32'(overflow_o), 32'd1);
        run_frame(100, 1, 0, -1);
        chk("ovf_next_header", got[0], 32'hD0D0_0001);
        chk("ovf_still", 32'(overflow_o), 32'd1);

        // Trigger on the cycle of the final acceptance is also dropped.
        do_reset();
        run_frame(100, 0, 85, -1);
        chk("ovf_last_cycle", 32'(overflow_o), 32'd1);

        // Reset during register word 12.
        run_frame(70, 1, 0, 17);
        chk("post_rst_ovf", 32'(overflow_o), 32'd0);
        run_frame(100, 0, 0, -1);
        chk("post_rst_header", got[0], 32'hD0D0_0000);
        chk("post_rst_cycle", got[1], 32'd0);
        chk("post_rst_stall", got[3], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
